// File: rtl/mest_pro_run_checker.sv
// Run controller for the MESTPro core: sequences core reset/start over a batch of runs,
// checks each valid result against a loadable expected table and reports one verdict.
module mest_pro_run_checker #(
  parameter int DATA_WIDTH     = 8,
  parameter int EXP_DEPTH      = 256,
  parameter int NUM_RUNS       = 4,
  parameter int RESET_CYCLES   = 10,
  parameter int START_DELAY    = 10,
  parameter int TIMEOUT_CYCLES = 4096,
  localparam int AW = $clog2(EXP_DEPTH),
  localparam int RW = $clog2(NUM_RUNS + 1)
) (
  input  logic                  clk,
  input  logic                  i_reset_n,
  input  logic                  i_go,
  input  logic [AW:0]           i_exp_len,
  input  logic                  i_exp_wr_en,
  input  logic [AW-1:0]         i_exp_wr_addr,
  input  logic [DATA_WIDTH+1:0] i_exp_wr_data,
  output logic                  o_core_reset_n,
  output logic                  o_core_start,
  input  logic [DATA_WIDTH-1:0] i_result,
  input  logic                  i_valid_result,
  input  logic                  i_carry,
  input  logic                  i_zero_flag,
  input  logic                  i_all_done,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic                  o_timeout,
  output logic [15:0]           o_err_count,
  output logic [RW-1:0]         o_first_err_run,
  output logic [AW:0]           o_first_err_idx,
  output logic [RW-1:0]         o_run_idx
);

  localparam int CW = $clog2((RESET_CYCLES > START_DELAY ? RESET_CYCLES : START_DELAY) + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [AW:0]   DEPTH_C  = (AW+1)'(EXP_DEPTH);
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST = CW'(START_DELAY - 1);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RUNS_C   = RW'(NUM_RUNS);

  typedef enum logic [2:0] {
    S_IDLE, S_CORE_RST, S_SETTLE, S_START, S_RUN, S_NEXT, S_DONE
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  logic [WW-1:0] wd_reg;
  logic [AW:0]   count_reg, count_next, count_plus, count_final;
  logic [EW-1:0] mem [EXP_DEPTH];
  logic [EW-1:0] exp_q_reg;
  logic [EW-1:0] obs;
  logic [RW-1:0] run_plus;
  logic          in_run, idle_cyc, mismatch, overrun, len_err, wd_hit, err_any;

  always_comb begin
    obs         = {i_zero_flag, i_carry, i_result};
    in_run      = (state_reg == S_RUN);
    // Saturating count keeps a long overrun from wrapping back onto a valid length.
    count_plus  = (count_reg == '1) ? count_reg : count_reg + 1'b1;
    count_final = i_valid_result ? count_plus : count_reg;
    idle_cyc    = !i_valid_result && !i_all_done;
    overrun     = in_run && i_valid_result && (count_reg >= DEPTH_C);
    mismatch    = in_run && i_valid_result && (count_reg < DEPTH_C) && (obs != exp_q_reg);
    len_err     = in_run && i_all_done && (count_final != i_exp_len);
    wd_hit      = in_run && idle_cyc && (wd_reg == WD_LAST);
    err_any     = mismatch || overrun || len_err || wd_hit;
    run_plus    = o_run_idx + 1'b1;
    count_next  = count_reg;
    if (state_reg == S_START) count_next = '0;
    else if (in_run)          count_next = count_final;
  end

  // Expected word is prefetched from the next count so it is ready when the result arrives.
  always_ff @(posedge clk) begin
    if (i_exp_wr_en && !o_busy) mem[i_exp_wr_addr] <= i_exp_wr_data;
    exp_q_reg <= mem[count_next[AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      state_reg       <= S_IDLE;
      cnt_reg         <= '0;
      wd_reg          <= '0;
      count_reg       <= '0;
      o_core_reset_n  <= 1'b0;
      o_core_start    <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_timeout       <= 1'b0;
      o_err_count     <= '0;
      o_first_err_run <= '0;
      o_first_err_idx <= '0;
      o_run_idx       <= '0;
    end else begin
      count_reg <= count_next;
      if (err_any) begin
        if (o_err_count != 16'hFFFF) o_err_count <= o_err_count + 16'd1;
        if (o_err_count == 16'd0) begin
          o_first_err_run <= o_run_idx;
          o_first_err_idx <= count_reg;
        end
      end
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (i_go) begin
            state_reg       <= S_CORE_RST;
            cnt_reg         <= '0;
            o_busy          <= 1'b1;
            o_done          <= 1'b0;
            o_pass          <= 1'b0;
            o_timeout       <= 1'b0;
            o_err_count     <= '0;
            o_first_err_run <= '0;
            o_first_err_idx <= '0;
            o_run_idx       <= '0;
          end
        end
        S_CORE_RST: begin
          if (cnt_reg == RST_LAST) begin
            state_reg      <= S_SETTLE;
            cnt_reg        <= '0;
            o_core_reset_n <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_SETTLE: begin
          if (cnt_reg == SET_LAST) begin
            state_reg    <= S_START;
            o_core_start <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        S_START: begin
          state_reg    <= S_RUN;
          o_core_start <= 1'b0;
          wd_reg       <= '0;
        end
        S_RUN: begin
          wd_reg <= idle_cyc ? wd_reg + 1'b1 : '0;
          if (wd_hit) o_timeout <= 1'b1;
          if (i_all_done || wd_hit) state_reg <= S_NEXT;
        end
        S_NEXT: begin
          o_run_idx      <= run_plus;
          o_core_reset_n <= 1'b0;
          cnt_reg        <= '0;
          if (run_plus < RUNS_C) begin
            state_reg <= S_CORE_RST;
          end else begin
            state_reg <= S_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_pass    <= (o_err_count == 16'd0) && !o_timeout;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
